// File: rtl/cnn_window_scheduler.sv
// -----------------------------------------------------------------------------
// cnn_window_scheduler
//
// Sequencing controller for a multi-channel KxK sliding-window line buffer.
// Walks the zero-padded frame in raster order and issues one shift beat per
// padded position. Border positions are injected as pad beats without taking
// input. Only stride-aligned window positions are presented downstream, each
// one tagged with its output-map row/column.
//
// Optional feature:
//   CNN_SCHED_ABORT_EN  when defined, abort=1 in RUN/FLUSH drops the frame and
//                       returns to IDLE on the next cycle with no done pulse.
//                       When undefined, abort is ignored.
//
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   start               begin one frame (only sampled in IDLE)
//   abort               frame abort (see CNN_SCHED_ABORT_EN)
//   s_tvalid/s_tready   upstream pixel handshake
//   shift_en            window buffer advances one padded position this cycle
//   pad_sel             buffer loads zero instead of the input pixel
//   m_tvalid/m_tready   downstream window handshake (1-deep output slot)
//   m_tlast             last window of the frame
//   out_row/out_col     output-map coordinates of the presented window
//   busy                frame in progress (RUN/FLUSH)
//   done                one-cycle pulse at frame completion
// -----------------------------------------------------------------------------
module cnn_window_scheduler #(
  parameter int IMAGE_WIDTH  = 224,
  parameter int IMAGE_HEIGHT = 224,
  parameter int WINDOW_ROWS  = 3,
  parameter int WINDOW_COLS  = 3,
  parameter int STRIDE       = 1,
  parameter int PADDING      = 1,
  parameter int DILATION     = 1,
  localparam int PW    = IMAGE_WIDTH + 2 * PADDING,
  localparam int PH    = IMAGE_HEIGHT + 2 * PADDING,
  localparam int EC    = 1 + (WINDOW_COLS - 1) * DILATION,
  localparam int ER    = 1 + (WINDOW_ROWS - 1) * DILATION,
  localparam int OUT_W = (PW - EC) / STRIDE + 1,
  localparam int OUT_H = (PH - ER) / STRIDE + 1,
  localparam int ROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1,
  localparam int COL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             s_tvalid,
  output logic             s_tready,
  output logic             shift_en,
  output logic             pad_sel,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic [ROW_W-1:0] out_row,
  output logic [COL_W-1:0] out_col,
  output logic             busy,
  output logic             done
);

  // Position counters carry one spare bit so the upper pad boundary always fits.
  localparam int PR_W = $clog2(PH + 1);
  localparam int PC_W = $clog2(PW + 1);
  localparam int RI_W = $clog2(OUT_H + 1);
  localparam int CI_W = $clog2(OUT_W + 1);
  localparam int SP_W = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  localparam logic [PR_W-1:0] PR_LAST   = PR_W'(PH - 1);
  localparam logic [PR_W-1:0] PR_PAD_LO = PR_W'(PADDING);
  localparam logic [PR_W-1:0] PR_PAD_HI = PR_W'(PADDING + IMAGE_HEIGHT);
  localparam logic [PR_W-1:0] PR_EMIT   = PR_W'(ER - 1);
  localparam logic [PC_W-1:0] PC_LAST   = PC_W'(PW - 1);
  localparam logic [PC_W-1:0] PC_PAD_LO = PC_W'(PADDING);
  localparam logic [PC_W-1:0] PC_PAD_HI = PC_W'(PADDING + IMAGE_WIDTH);
  localparam logic [PC_W-1:0] PC_EMIT   = PC_W'(EC - 1);
  localparam logic [SP_W-1:0] SP_LAST   = SP_W'(STRIDE - 1);
  localparam logic [RI_W-1:0] RI_END    = RI_W'(OUT_H);
  localparam logic [RI_W-1:0] RI_LAST   = RI_W'(OUT_H - 1);
  localparam logic [CI_W-1:0] CI_END    = CI_W'(OUT_W);
  localparam logic [CI_W-1:0] CI_LAST   = CI_W'(OUT_W - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t          state;
  logic [PR_W-1:0] pr;
  logic [PC_W-1:0] pc;
  // Stride phase and output index per axis replace any division/modulo.
  logic [SP_W-1:0] row_ph, col_ph;
  logic [RI_W-1:0] row_idx;
  logic [CI_W-1:0] col_idx;

  logic run, is_pad, slot_free, beat, abort_hit;
  logic row_emit, col_emit, last_beat;

  assign run       = (state == RUN);
  assign is_pad    = (pr < PR_PAD_LO) | (pr >= PR_PAD_HI) |
                     (pc < PC_PAD_LO) | (pc >= PC_PAD_HI);
  assign slot_free = ~m_tvalid | m_tready;

`ifdef CNN_SCHED_ABORT_EN
  assign abort_hit = abort & ((state == RUN) | (state == FLUSH));
`else
  // abort is accepted on the port but can never take effect.
  assign abort_hit = abort & 1'b0;
`endif

  // Abort wins over any beat in the same cycle, so nothing is shifted or taken.
  assign beat      = run & slot_free & (is_pad | s_tvalid) & ~abort_hit;
  assign s_tready  = run & ~is_pad & slot_free & ~abort_hit;
  assign shift_en  = beat;
  assign pad_sel   = run & is_pad;

  // Row/column is an output position when past the kernel extent, on a stride
  // phase of zero and still inside the floor-truncated output map.
  assign row_emit  = (pr >= PR_EMIT) & (row_ph == '0) & (row_idx < RI_END);
  assign col_emit  = (pc >= PC_EMIT) & (col_ph == '0) & (col_idx < CI_END);
  assign last_beat = (pr == PR_LAST) & (pc == PC_LAST);

  // Raster position walker. Wraps to zero after the last beat so a new frame
  // always starts at (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: registers use non-blocking assignment so every flop samples the
      // pre-edge values; blocking here would chain updates within one edge.
      pr      <= '0;
      pc      <= '0;
      row_ph  <= '0;
      col_ph  <= '0;
      row_idx <= '0;
      col_idx <= '0;
    end else if (abort_hit) begin
      pr      <= '0;
      pc      <= '0;
      row_ph  <= '0;
      col_ph  <= '0;
      row_idx <= '0;
      col_idx <= '0;
    end else if (beat) begin
      if (pc == PC_LAST) begin
        pc      <= '0;
        col_ph  <= '0;
        col_idx <= '0;
        if (pr == PR_LAST) begin
          pr      <= '0;
          row_ph  <= '0;
          row_idx <= '0;
        end else begin
          pr <= pr + 1'b1;
          if (pr >= PR_EMIT) begin
            row_ph <= (row_ph == SP_LAST) ? '0 : row_ph + 1'b1;
            if (row_emit) row_idx <= row_idx + 1'b1;
          end
        end
      end else begin
        pc <= pc + 1'b1;
        if (pc >= PC_EMIT) begin
          col_ph <= (col_ph == SP_LAST) ? '0 : col_ph + 1'b1;
          if (col_emit) col_idx <= col_idx + 1'b1;
        end
      end
    end
  end

  // Frame FSM with the registered output slot, busy and done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      out_row  <= '0;
      out_col  <= '0;
    end else if (abort_hit) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          // Accept and a new emit beat in one cycle keep the slot full.
          if (beat & row_emit & col_emit) begin
            m_tvalid <= 1'b1;
            out_row  <= ROW_W'(row_idx);
            out_col  <= COL_W'(col_idx);
            m_tlast  <= (row_idx == RI_LAST) & (col_idx == CI_LAST);
          end else if (m_tready) begin
            m_tvalid <= 1'b0;
          end
          if (beat & last_beat) state <= FLUSH;
        end
        FLUSH: begin
          // Wait for the final window to drain before signalling completion.
          if (slot_free) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            m_tvalid <= 1'b0;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_window_scheduler.sv
// -----------------------------------------------------------------------------
// tb_cnn_window_scheduler
//
// Three scheduler instances share one random input stream:
//   d0: 4x4 image, 3x3 kernel, stride 1, pad 1, dilation 1
//   d1: 4x4 image, 3x3 kernel, stride 2, pad 1, dilation 1
//   d2: 5x5 image, 3x3 kernel, stride 1, pad 0, dilation 2
// A reference model tracks each frame as a linear padded-position index and
// derives pad/emit/tags with plain division and modulo. All outputs are
// compared every cycle, and per-frame beat/pad/accept/window totals are
// compared on the done cycle.
// -----------------------------------------------------------------------------
module tb_cnn_window_scheduler;

`ifdef CNN_SCHED_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  logic clk, rst_n, start, abort, s_tvalid, m_tready;
  logic [2:0]  o_trdy, o_shift, o_pad, o_mv, o_ml, o_busy, o_done;
  logic [31:0] o_row [3];
  logic [31:0] o_col [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W  = (g == 2) ? 5 : 4;
    localparam int S  = (g == 1) ? 2 : 1;
    localparam int P  = (g == 2) ? 0 : 1;
    localparam int D  = (g == 2) ? 2 : 1;
    localparam int OW = (W + 2 * P - (1 + 2 * D)) / S + 1;
    localparam int TW = (OW > 1) ? $clog2(OW) : 1;
    logic [TW-1:0] row, col;

    cnn_window_scheduler #(
      .IMAGE_WIDTH(W), .IMAGE_HEIGHT(W), .WINDOW_ROWS(3), .WINDOW_COLS(3),
      .STRIDE(S), .PADDING(P), .DILATION(D)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .s_tvalid(s_tvalid), .s_tready(o_trdy[g]),
      .shift_en(o_shift[g]), .pad_sel(o_pad[g]),
      .m_tvalid(o_mv[g]), .m_tready(m_tready), .m_tlast(o_ml[g]),
      .out_row(row), .out_col(col),
      .busy(o_busy[g]), .done(o_done[g])
    );
    assign o_row[g] = 32'(row);
    assign o_col[g] = 32'(col);
  end

  // ---------------------------------------------------------------- model
  typedef struct {
    int w, h, s, p, pw, ph, ec, er, ow, oh;
  } cfg_t;

  typedef enum int {M_IDLE, M_RUN, M_FLUSH, M_DONE} mph_e;

  typedef struct {
    mph_e ph;
    int   pos;
    bit   v;
    int   row;
    int   col;
    bit   last;
  } mst_t;

  cfg_t cfg [3];
  mst_t ms  [3];
  int cnt_beat [3];
  int cnt_pad  [3];
  int cnt_acc  [3];
  int cnt_win  [3];
  int n_pass = 0;
  int n_fail = 0;

  function automatic cfg_t mk_cfg(int w, int h, int kr, int kc, int s, int p, int d);
    cfg_t c;
    c.w  = w;
    c.h  = h;
    c.s  = s;
    c.p  = p;
    c.pw = w + 2 * p;
    c.ph = h + 2 * p;
    c.ec = 1 + (kc - 1) * d;
    c.er = 1 + (kr - 1) * d;
    c.ow = (c.pw - c.ec) / s + 1;
    c.oh = (c.ph - c.er) / s + 1;
    return c;
  endfunction

  function automatic bit m_is_pad(cfg_t c, int pos);
    int r = pos / c.pw;
    int q = pos % c.pw;
    return (r < c.p) || (r >= c.p + c.h) || (q < c.p) || (q >= c.p + c.w);
  endfunction

  // Output-map coordinates of the window completed at this position, if any.
  function automatic bit m_emit(cfg_t c, int pos, output int r, output int q);
    int dr = pos / c.pw - (c.er - 1);
    int dc = pos % c.pw - (c.ec - 1);
    r = (dr >= 0) ? dr / c.s : 0;
    q = (dc >= 0) ? dc / c.s : 0;
    return (dr >= 0) && (dc >= 0) && (dr % c.s == 0) && (dc % c.s == 0) &&
           (r < c.oh) && (q < c.ow);
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk(int i, string name, logic [31:0] got, logic [31:0] exp);
    check($sformatf("d%0d.%s t=%0t", i, name, $time), got, exp);
  endtask

  task automatic model_cycle(int i, bit sv, bit mr, bit st, bit ab);
    cfg_t c;
    mst_t m;
    bit run, ab_hit, free, pad, beat, em;
    int er, ec;
    c      = cfg[i];
    m      = ms[i];
    run    = (m.ph == M_RUN);
    ab_hit = ABORT_EN && ab && (m.ph == M_RUN || m.ph == M_FLUSH);
    free   = !m.v || mr;
    pad    = run && m_is_pad(c, m.pos);
    beat   = run && free && (pad || sv) && !ab_hit;
    em     = m_emit(c, m.pos, er, ec);

    chk(i, "busy",     32'(o_busy[i]),  32'(m.ph == M_RUN || m.ph == M_FLUSH));
    chk(i, "done",     32'(o_done[i]),  32'(m.ph == M_DONE));
    chk(i, "m_tvalid", 32'(o_mv[i]),    32'(m.v));
    chk(i, "s_tready", 32'(o_trdy[i]),  32'(run && !pad && free && !ab_hit));
    chk(i, "shift_en", 32'(o_shift[i]), 32'(beat));
    chk(i, "pad_sel",  32'(o_pad[i]),   32'(pad));
    if (m.v) begin
      chk(i, "out_row", o_row[i], m.row);
      chk(i, "out_col", o_col[i], m.col);
      chk(i, "m_tlast", 32'(o_ml[i]), 32'(m.last));
    end
    if (m.ph == M_DONE) begin
      chk(i, "n_beats",   cnt_beat[i], c.pw * c.ph);
      chk(i, "n_pads",    cnt_pad[i],  c.pw * c.ph - c.w * c.h);
      chk(i, "n_accepts", cnt_acc[i],  c.w * c.h);
      chk(i, "n_windows", cnt_win[i],  c.ow * c.oh);
    end

    if (o_shift[i]) cnt_beat[i]++;
    if (o_shift[i] && o_pad[i]) cnt_pad[i]++;
    if (sv && o_trdy[i]) cnt_acc[i]++;
    if (o_mv[i] && mr) cnt_win[i]++;

    if (ab_hit) begin
      m.ph  = M_IDLE;
      m.pos = 0;
      m.v   = 1'b0;
    end else begin
      case (m.ph)
        M_IDLE: if (st) begin
          m.ph = M_RUN;
          m.pos = 0;
          cnt_beat[i] = 0;
          cnt_pad[i]  = 0;
          cnt_acc[i]  = 0;
          cnt_win[i]  = 0;
        end
        M_RUN: begin
          if (beat && em) begin
            m.v    = 1'b1;
            m.row  = er;
            m.col  = ec;
            m.last = (er == c.oh - 1) && (ec == c.ow - 1);
          end else if (mr) begin
            m.v = 1'b0;
          end
          if (beat) begin
            m.pos++;
            if (m.pos == c.pw * c.ph) m.ph = M_FLUSH;
          end
        end
        M_FLUSH: if (free) begin
          m.v  = 1'b0;
          m.ph = M_DONE;
        end
        default: m.ph = M_IDLE;
      endcase
    end
    ms[i] = m;
  endtask

  // --------------------------------------------------------------- driving
  task automatic step(bit sv, bit mr, bit st, bit ab);
    @(negedge clk);
    s_tvalid = sv;
    m_tready = mr;
    start    = st;
    abort    = ab;
    #1;
    for (int i = 0; i < 3; i++) model_cycle(i, sv, mr, st, ab);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk(i, "rst.busy",     32'(o_busy[i]),  0);
      chk(i, "rst.done",     32'(o_done[i]),  0);
      chk(i, "rst.m_tvalid", 32'(o_mv[i]),    0);
      chk(i, "rst.m_tlast",  32'(o_ml[i]),    0);
      chk(i, "rst.s_tready", 32'(o_trdy[i]),  0);
      chk(i, "rst.shift_en", 32'(o_shift[i]), 0);
      chk(i, "rst.pad_sel",  32'(o_pad[i]),   0);
      chk(i, "rst.out_row",  o_row[i],        0);
      chk(i, "rst.out_col",  o_col[i],        0);
      ms[i] = '{M_IDLE, 0, 1'b0, 0, 0, 1'b0};
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic bit all_in_run();
    bit r = 1'b1;
    for (int i = 0; i < 3; i++) if (ms[i].ph != M_RUN) r = 1'b0;
    return r;
  endfunction

  // One frame on all instances. abort_pos/rst_cycle < 0 disable those events.
  task automatic run_frame(int sv_pct, int mr_pct, bit toggle_sv, bit restart,
                           bit stall11, int abort_pos, int rst_cycle);
    int cyc = 0;
    int stall_left = 0;
    bit stall_done = 1'b0;
    bit active = 1'b1;
    bit sv, mr, st, ab;
    while (active && cyc < 2000) begin
      if (cyc == rst_cycle) begin
        do_reset();
        active = 1'b0;
      end else begin
        if (stall11 && !stall_done && ms[0].v && ms[0].row == 1 && ms[0].col == 1) begin
          stall_left = 5;
          stall_done = 1'b1;
        end
        sv = toggle_sv ? (cyc % 2 == 0) : (int'($urandom_range(99)) < sv_pct);
        mr = (stall_left > 0) ? 1'b0 : (int'($urandom_range(99)) < mr_pct);
        if (stall_left > 0) stall_left--;
        st = (cyc == 0) || (restart && all_in_run() && $urandom_range(3) == 0);
        ab = (abort_pos >= 0) && (ms[0].ph == M_RUN) && (ms[0].pos == abort_pos);
        step(sv, mr, st, ab);
        cyc++;
        active = 1'b0;
        for (int i = 0; i < 3; i++) if (ms[i].ph != M_IDLE) active = 1'b1;
      end
    end
    // Settle cycle; a frame that never finished shows up as busy here.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) chk(i, "idle_after_frame", 32'(o_busy[i]), 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    cfg[0] = mk_cfg(4, 4, 3, 3, 1, 1, 1);
    cfg[1] = mk_cfg(4, 4, 3, 3, 2, 1, 1);
    cfg[2] = mk_cfg(5, 5, 3, 3, 1, 0, 2);

    do_reset();
    // Full throughput.
    run_frame(100, 100, 1'b0, 1'b0, 1'b0, -1, -1);
    // Random input gaps and downstream back-pressure.
    run_frame(70, 60, 1'b0, 1'b0, 1'b0, -1, -1);
    run_frame(40, 85, 1'b0, 1'b0, 1'b0, -1, -1);
    run_frame(90, 30, 1'b0, 1'b0, 1'b0, -1, -1);
    // Downstream held off for 5 cycles on window (1,1) of d0.
    run_frame(100, 100, 1'b0, 1'b0, 1'b1, -1, -1);
    // s_tvalid toggling with start pulses while busy.
    run_frame(0, 80, 1'b1, 1'b1, 1'b0, -1, -1);
    // Abort at beat 10 of d0, then a clean frame.
    run_frame(100, 100, 1'b0, 1'b0, 1'b0, 10, -1);
    run_frame(100, 100, 1'b0, 1'b0, 1'b0, -1, -1);
    // Asynchronous reset mid-frame, then a clean frame.
    run_frame(80, 80, 1'b0, 1'b0, 1'b0, -1, 20);
    run_frame(100, 100, 1'b0, 1'b0, 1'b0, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
